fdiv_arb: RTL and testbench

FDIV_ARB -- requirements
Module: fdiv_arb

---
 rtl/fdiv_arb_pkg.sv | 26 ++
 rtl/fdiv_tag_pipe.sv | 39 +++
 rtl/fdiv_arb.sv | 89 ++++++++
 tb/tb_fdiv_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_arb_pkg.sv
// fdiv_arb_pkg: shared defaults, requester id and tag-pipe entry for fdiv_arb.
// FDIV_ARB_DZ_FLAG_EN adds the divide-by-zero bit to the pipe entry.
package fdiv_arb_pkg;
   localparam int LAT_DEF   = 5;
   localparam int TAG_W_DEF = 5;
   // Entry tag field is sized for the widest supported TAG_W; narrower tags are zero-extended.
   localparam int TAG_W_MAX = 16;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

   typedef struct packed {
      logic                 valid;
      req_id_t              id;
      logic [TAG_W_MAX-1:0] tag;
`ifdef FDIV_ARB_DZ_FLAG_EN
      logic                 dz;
`endif
   } pipe_entry_t;

   function automatic logic is_zero_divisor(input logic [30:0] mag);
      return mag == 31'd0;
   endfunction
endpackage

// File: rtl/fdiv_tag_pipe.sv
// fdiv_tag_pipe: LAT+1-deep, never-stalling shift register of pipe entries.
// flush0/flush1 invalidate every entry of that requester, including the one shifting in.
module fdiv_tag_pipe
   import fdiv_arb_pkg::*;
#(
   parameter int LAT = LAT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  pipe_entry_t in_entry,
   input  logic        flush0,
   input  logic        flush1,
   output pipe_entry_t tail,
   output logic        busy
);
   pipe_entry_t stage [LAT+1];

   function automatic pipe_entry_t kill(input pipe_entry_t e, input logic f0, input logic f1);
      pipe_entry_t r;
      r       = e;
      r.valid = e.valid & ~((e.id == REQ0) ? f0 : f1);
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst)
      if (!rst)
         for (int i = 0; i <= LAT; i++) stage[i] <= '0;
      else begin
         stage[0] <= kill(in_entry, flush0, flush1);
         for (int i = 1; i <= LAT; i++) stage[i] <= kill(stage[i-1], flush0, flush1);
      end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i <= LAT; i++) busy = busy | stage[i].valid;
   end

   assign tail = stage[LAT];
endmodule

// File: rtl/fdiv_arb.sv
// fdiv_arb: round-robin arbiter sharing one pipelined FP32 divider between two requesters.
// Define FDIV_ARB_DZ_FLAG_EN to add the rsp_dz divide-by-zero flag output.
module fdiv_arb
   import fdiv_arb_pkg::*;
#(
   parameter int LAT   = LAT_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [TAG_W-1:0] req1_tag,
   input  logic             flush0,
   input  logic             flush1,
   output logic [31:0]      div_a,
   output logic [31:0]      div_b,
   input  logic [31:0]      div_result,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
`ifdef FDIV_ARB_DZ_FLAG_EN
   ,
   output logic             rsp_dz
`endif
);
   logic        rr, elig0, elig1, grant0, grant1, acc, unused_tag;
   pipe_entry_t in_entry, tail;

   // A requester being flushed drops out of arbitration so the other one can win.
   assign elig0      = req0_valid & ~flush0;
   assign elig1      = req1_valid & ~flush1;
   assign grant0     = elig0 & (~elig1 | ~rr);
   assign grant1     = elig1 & (~elig0 | rr);
   assign req0_ready = grant0 & rst;
   assign req1_ready = grant1 & rst;
   assign acc        = req0_ready | req1_ready;

   always_comb begin
      in_entry       = '0;
      in_entry.valid = acc;
      in_entry.id    = req1_ready ? REQ1 : REQ0;
      in_entry.tag   = TAG_W_MAX'(req1_ready ? req1_tag : req0_tag);
`ifdef FDIV_ARB_DZ_FLAG_EN
      in_entry.dz    = is_zero_divisor(req1_ready ? req1_b[30:0] : req0_b[30:0]);
`endif
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rr    <= 1'b0;
         div_a <= '0;
         div_b <= '0;
      end else begin
         if (elig0 & elig1) rr <= ~rr;
         if (acc) begin
            div_a <= req1_ready ? req1_a : req0_a;
            div_b <= req1_ready ? req1_b : req0_b;
         end
      end

   fdiv_tag_pipe #(.LAT(LAT)) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_entry (in_entry),
      .flush0   (flush0),
      .flush1   (flush1),
      .tail     (tail),
      .busy     (busy)
   );

   assign rsp0_valid = tail.valid & (tail.id == REQ0);
   assign rsp1_valid = tail.valid & (tail.id == REQ1);
   assign rsp_data   = div_result;
   assign rsp_tag    = tail.tag[TAG_W-1:0];
   assign unused_tag = ^tail.tag;
`ifdef FDIV_ARB_DZ_FLAG_EN
   assign rsp_dz     = tail.dz;
`endif
endmodule

// File: tb/tb_fdiv_arb.sv
// tb_fdiv_arb: randomized and directed checks of fdiv_arb against a transaction-level model.
// Build with FDIV_ARB_DZ_FLAG_EN defined to also check rsp_dz.
module tb_fdiv_arb;
   localparam int LAT   = 5;
   localparam int TAG_W = 5;

   typedef struct {
      int               due;
      int               id;
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      bit               dz;
   } exp_t;

   logic             clk = 1'b0, rst = 1'b0;
   logic             req0_valid = 1'b0, req1_valid = 1'b0, flush0 = 1'b0, flush1 = 1'b0;
   logic [31:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
   logic             req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
   logic [31:0]      div_a, div_b, div_result, rsp_data;
   logic [TAG_W-1:0] rsp_tag;
`ifdef FDIV_ARB_DZ_FLAG_EN
   logic             rsp_dz;
`endif
   logic [31:0]      dpipe [LAT] = '{default: '0};

   int   n_checks = 0, n_fail = 0, edge_n = 0;
   bit   fav = 1'b0;
   logic [31:0] last_a = '0, last_b = '0;
   exp_t pend [$];

   always #5 clk = ~clk;

   // Stand-in divider: LAT register stages, exact for the directed 6.0/2.0 case.
   function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk) begin
      dpipe[0] <= fake_div(div_a, div_b);
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
   end
   assign div_result = dpipe[LAT-1];

   fdiv_arb #(.LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
      .flush0(flush0), .flush1(flush1),
      .div_a(div_a), .div_b(div_b), .div_result(div_result),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .busy(busy)
`ifdef FDIV_ARB_DZ_FLAG_EN
      , .rsp_dz(rsp_dz)
`endif
   );

   // One clock of the transaction model: called just after an edge with inputs already driven.
   task automatic step();
      int          w, found;
      bit          e0, e1;
      logic [31:0] sa, sb;
      logic [1:0]  want_v;
      exp_t        e;
      #3;
      e0 = req0_valid && !flush0;
      e1 = req1_valid && !flush1;
      w  = (e0 && e1) ? int'(fav) : e0 ? 0 : e1 ? 1 : -1;
      if (e0 && e1) fav = !fav;
      n_checks++;
      if ({req0_ready, req1_ready} !== {w == 0, w == 1}) begin
         n_fail++;
         $display("FAIL ready edge %0d: got %b%b want %b%b", edge_n + 1, req0_ready, req1_ready, w == 0, w == 1);
      end
      for (int i = pend.size() - 1; i >= 0; i--)
         if ((pend[i].id == 0 && flush0) || (pend[i].id == 1 && flush1)) pend.delete(i);
      if (w >= 0) begin
         sa     = (w == 1) ? req1_a : req0_a;
         sb     = (w == 1) ? req1_b : req0_b;
         e.due  = edge_n + 1 + LAT;
         e.id   = w;
         e.tag  = (w == 1) ? req1_tag : req0_tag;
         e.data = fake_div(sa, sb);
         e.dz   = (sb[30:0] == 31'd0);
         pend.push_back(e);
         last_a = sa;
         last_b = sb;
      end
      @(posedge clk);
      #1;
      edge_n++;
      n_checks++;
      if (div_a !== last_a || div_b !== last_b) begin
         n_fail++;
         $display("FAIL operands edge %0d: got %h/%h want %h/%h", edge_n, div_a, div_b, last_a, last_b);
      end
      found = -1;
      foreach (pend[i]) if (pend[i].due == edge_n) found = i;
      want_v = 2'b00;
      if (found >= 0) want_v = (pend[found].id == 0) ? 2'b10 : 2'b01;
      n_checks++;
      if ({rsp0_valid, rsp1_valid} !== want_v) begin
         n_fail++;
         $display("FAIL rsp_valid edge %0d: got %b%b want %b", edge_n, rsp0_valid, rsp1_valid, want_v);
      end
      if (found >= 0) begin
         n_checks++;
         if (rsp_tag !== pend[found].tag || rsp_data !== pend[found].data) begin
            n_fail++;
            $display("FAIL rsp_payload edge %0d: got tag %0d data %h want tag %0d data %h",
                     edge_n, rsp_tag, rsp_data, pend[found].tag, pend[found].data);
         end
`ifdef FDIV_ARB_DZ_FLAG_EN
         n_checks++;
         if (rsp_dz !== pend[found].dz) begin
            n_fail++;
            $display("FAIL rsp_dz edge %0d: got %b want %b", edge_n, rsp_dz, pend[found].dz);
         end
`endif
      end
      n_checks++;
      if (busy !== (pend.size() != 0)) begin
         n_fail++;
         $display("FAIL busy edge %0d: got %b want %b", edge_n, busy, pend.size() != 0);
      end
      while (pend.size() != 0 && pend[0].due <= edge_n) void'(pend.pop_front());
   endtask

   task automatic idle(input int n);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      flush0     = 1'b0;
      flush1     = 1'b0;
      repeat (n) step();
   endtask

   task automatic check_quiet(input string name);
      n_checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0 || div_a !== '0 || div_b !== '0) begin
         n_fail++;
         $display("FAIL %s: got rdy %b%b rsp %b%b busy %b div %h/%h want all zero", name,
                  req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, div_a, div_b);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check_quiet("reset_async");
      @(posedge clk);
      #1;
      check_quiet("reset_held");
      n_checks++;
      if ($isunknown(rsp_tag) || $isunknown(rsp_data)) begin
         n_fail++;
         $display("FAIL reset_rsp_x: got tag %b data %h want known", rsp_tag, rsp_data);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst        = 1'b1;
      pend.delete();
      fav    = 1'b0;
      last_a = '0;
      last_b = '0;
   endtask

   task automatic test_single();
      req0_valid = 1'b1;
      req0_a     = 32'h40C0_0000;
      req0_b     = 32'h4000_0000;
      req0_tag   = 5'd3;
      step();
      idle(8);
   endtask

   task automatic test_contention();
      test_reset();
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1'b1;
         req1_valid = 1'b1;
         req0_a     = $urandom();
         req1_a     = $urandom();
         req0_tag   = TAG_W'(i);
         req1_tag   = TAG_W'(8 + i);
         #1;
         n_checks++;
         if (req1_ready !== (i % 2 == 1)) begin
            n_fail++;
            $display("FAIL contention_grant %0d: got req1_ready %b want %b", i, req1_ready, i % 2 == 1);
         end
         step();
      end
      idle(8);
   endtask

   task automatic test_flush();
      req1_valid = 1'b1;
      req1_tag   = 5'd10;
      req1_a     = 32'h1111_0000;
      step();
      req1_tag   = 5'd11;
      req1_a     = 32'h2222_0000;
      step();
      req1_valid = 1'b0;
      req0_valid = 1'b1;
      req0_tag   = 5'd12;
      req0_a     = 32'h3333_0000;
      step();
      req0_valid = 1'b0;
      flush1     = 1'b1;
      step();
      idle(8);
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 3; i++) begin
         req0_valid = (i != 1);
         req1_valid = (i == 1);
         req0_tag   = TAG_W'(20 + i);
         req1_tag   = TAG_W'(20 + i);
         step();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check_quiet("midflight_reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      pend.delete();
      fav    = 1'b0;
      last_a = '0;
      last_b = '0;
      idle(10);
   endtask

   task automatic test_flush_and_request();
      test_reset();
      req0_valid = 1'b1;
      req0_tag   = 5'd7;
      step();
      req1_valid = 1'b1;
      req1_tag   = 5'd9;
      flush0     = 1'b1;
      step();
      req1_valid = 1'b0;
      step();
      idle(8);
   endtask

`ifdef FDIV_ARB_DZ_FLAG_EN
   task automatic test_dz();
      req0_valid = 1'b1;
      req0_a     = 32'h3F80_0000;
      req0_b     = 32'h8000_0000;
      req0_tag   = 5'd1;
      step();
      req0_b     = 32'h3F80_0000;
      req0_tag   = 5'd2;
      step();
      idle(8);
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         flush0     = ($urandom_range(0, 15) == 0);
         flush1     = ($urandom_range(0, 15) == 0);
         req0_a     = $urandom();
         req1_a     = $urandom();
         req0_b     = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom());
         req1_b     = ($urandom_range(0, 7) == 0) ? 32'h0000_0000 : 32'($urandom());
         req0_tag   = TAG_W'($urandom());
         req1_tag   = TAG_W'($urandom());
         step();
      end
      idle(8);
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_flush();
      test_reset_midflight();
      test_flush_and_request();
`ifdef FDIV_ARB_DZ_FLAG_EN
      test_dz();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
